// File: rtl/sort_pkg.sv
// Shared types for the packet sorter: controller state encoding and read-side flag bundle.
package sort_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RECV  = 3'd1,
        SORT  = 3'd2,
        READ  = 3'd3,
        DRAIN = 3'd4
    } sort_state_e;

    typedef struct packed {
        logic val;
        logic sop;
        logic eop;
    } sort_flags_t;

endpackage

// File: rtl/sort_ctrl_if.sv
// Bundle of the sorter controller's stream, RAM, sort-engine and output signals.
interface sort_ctrl_if #(
    parameter int unsigned AWIDTH = 4
);
    logic              val_i;
    logic              sop_i;
    logic              eop_i;
    logic              busy_o;
    logic              wr_en_o;
    logic [AWIDTH-1:0] wr_addr_o;
    logic              sort_start_o;
    logic [AWIDTH:0]   sort_len_o;
    logic              sort_done_i;
    logic              rd_en_o;
    logic [AWIDTH-1:0] rd_addr_o;
    logic              val_o;
    logic              sop_o;
    logic              eop_o;
    logic              clear_o;
    logic              overflow_o;
    logic              restart_o;

    // Controller side
    modport master (
        input  val_i, sop_i, eop_i, sort_done_i,
        output busy_o, wr_en_o, wr_addr_o, sort_start_o, sort_len_o,
               rd_en_o, rd_addr_o, val_o, sop_o, eop_o, clear_o,
               overflow_o, restart_o
    );

    // Environment side (stream source, RAM, sort engine, sink)
    modport slave (
        output val_i, sop_i, eop_i, sort_done_i,
        input  busy_o, wr_en_o, wr_addr_o, sort_start_o, sort_len_o,
               rd_en_o, rd_addr_o, val_o, sop_o, eop_o, clear_o,
               overflow_o, restart_o
    );
endinterface

// File: rtl/sort_flag_pipe.sv
// Delays the read-side {val, sop, eop} flags to line up with RAM read data.
module sort_flag_pipe
    import sort_pkg::*;
#(
    parameter int unsigned LATENCY = 1
) (
    input  logic        clk_i,
    input  logic        srst_i,
    input  sort_flags_t flags_i,
    output sort_flags_t flags_o
);

    sort_flags_t pipe_q [LATENCY];

    // Shift register, flushed by reset
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            for (int i = 0; i < int'(LATENCY); i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            pipe_q[0] <= flags_i;
            for (int i = 1; i < int'(LATENCY); i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign flags_o = pipe_q[LATENCY-1];

endmodule

// File: rtl/sort_ctrl.sv
// Packet sorter controller: captures a packet into the buffer, kicks the sort engine,
// then streams the sorted buffer back out with sop/eop framing.
module sort_ctrl
    import sort_pkg::*;
#(
    parameter int unsigned AWIDTH     = 4,
    parameter int unsigned RD_LATENCY = 1
) (
    input  logic       clk_i,
    input  logic       srst_i,
    sort_ctrl_if.master bus
);

    localparam int unsigned DEPTH = 2**AWIDTH;
    localparam int unsigned CW    = AWIDTH + 1;
    localparam int unsigned DW    = $clog2(RD_LATENCY + 1);

    sort_state_e       state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [CW-1:0]     len_q, len_d;
    logic [CW-1:0]     rd_q, rd_d;
    logic [DW-1:0]     drain_q, drain_d;
    logic              ovf_q, ovf_d;
    logic              restart_q, restart_d;
    logic              start_q, start_d;

    logic              busy_c;
    logic              accept_c;
    logic              rd_en_c;
    logic              wr_en_c;
    logic [AWIDTH-1:0] wr_addr_c;
    sort_flags_t       flags_in_c;
    sort_flags_t       flags_out;

    assign busy_c   = (state_q == SORT) || (state_q == READ) || (state_q == DRAIN);
    assign accept_c = bus.val_i && !busy_c;
    assign rd_en_c  = (state_q == READ);

    // Next-state, counter and write-port decode
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        len_d     = len_q;
        rd_d      = rd_q;
        drain_d   = drain_q;
        ovf_d     = ovf_q;
        restart_d = 1'b0;
        start_d   = 1'b0;
        wr_en_c   = 1'b0;
        wr_addr_c = '0;
        case (state_q)
            IDLE, RECV: begin
                if (accept_c && bus.sop_i) begin
                    // New packet (or restart of an unterminated one) always lands at address 0
                    wr_en_c   = 1'b1;
                    cnt_d     = CW'(1);
                    ovf_d     = 1'b0;
                    restart_d = (state_q == RECV);
                    if (bus.eop_i) begin
                        len_d   = CW'(1);
                        rd_d    = '0;
                        state_d = READ;
                    end else begin
                        state_d = RECV;
                    end
                end else if (accept_c && (state_q == RECV)) begin
                    if (cnt_q < CW'(DEPTH)) begin
                        wr_en_c   = 1'b1;
                        wr_addr_c = cnt_q[AWIDTH-1:0];
                        cnt_d     = cnt_q + CW'(1);
                    end else begin
                        ovf_d = 1'b1;
                    end
                    if (bus.eop_i) begin
                        len_d   = (cnt_q < CW'(DEPTH)) ? cnt_q + CW'(1) : CW'(DEPTH);
                        start_d = 1'b1;
                        state_d = SORT;
                    end
                end
            end
            SORT: begin
                if (bus.sort_done_i) begin
                    rd_d    = '0;
                    state_d = READ;
                end
            end
            READ: begin
                if (rd_q == len_q - CW'(1)) begin
                    rd_d    = '0;
                    drain_d = DW'(1);
                    state_d = DRAIN;
                end else begin
                    rd_d = rd_q + CW'(1);
                end
            end
            DRAIN: begin
                if (drain_q == DW'(RD_LATENCY)) begin
                    drain_d = '0;
                    state_d = IDLE;
                end else begin
                    drain_d = drain_q + DW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and control registers
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            len_q     <= '0;
            rd_q      <= '0;
            drain_q   <= '0;
            ovf_q     <= 1'b0;
            restart_q <= 1'b0;
            start_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            len_q     <= len_d;
            rd_q      <= rd_d;
            drain_q   <= drain_d;
            ovf_q     <= ovf_d;
            restart_q <= restart_d;
            start_q   <= start_d;
        end
    end

    assign flags_in_c.val = rd_en_c;
    assign flags_in_c.sop = rd_en_c && (rd_q == '0);
    assign flags_in_c.eop = rd_en_c && (rd_q == len_q - CW'(1));

    sort_flag_pipe #(
        .LATENCY (RD_LATENCY)
    ) u_flag_pipe (
        .clk_i   (clk_i),
        .srst_i  (srst_i),
        .flags_i (flags_in_c),
        .flags_o (flags_out)
    );

    assign bus.busy_o       = busy_c;
    assign bus.wr_en_o      = wr_en_c;
    assign bus.wr_addr_o    = wr_addr_c;
    assign bus.sort_start_o = start_q;
    assign bus.sort_len_o   = len_q;
    assign bus.rd_en_o      = rd_en_c;
    assign bus.rd_addr_o    = rd_q[AWIDTH-1:0];
    assign bus.val_o        = flags_out.val;
    assign bus.sop_o        = flags_out.sop;
    assign bus.eop_o        = flags_out.eop;
    assign bus.clear_o      = flags_out.eop;
    assign bus.overflow_o   = ovf_q;
    assign bus.restart_o    = restart_q;

endmodule

// File: tb/tb_sort_ctrl.sv
// Directed bench for sort_ctrl: one instance with RD_LATENCY=1 and one with RD_LATENCY=3,
// both driven by the same stimulus and observed by per-instance monitors.
module tb_sort_ctrl;

    logic clk = 1'b0;
    logic srst = 1'b1;
    logic val_r = 1'b0;
    logic sop_r = 1'b0;
    logic eop_r = 1'b0;
    logic done_r = 1'b0;
    int   cyc = 0;
    int   nchk = 0;
    int   errs = 0;

    // Monitor logs, instance with latency 1
    int wr_a[$];
    int st_c[$];
    int st_len[$];
    int rd_c[$];
    int rd_a[$];
    int vo_c[$];
    int vo_f[$];
    int rs_c[$];
    int ovf_c = -1;
    int busy_wr = 0;
    // Monitor logs, instance with latency 3
    int rd3_c[$];
    int vo3_c[$];
    int vo3_f[$];
    int busy_wr3 = 0;

    int te, s, tr;

    sort_ctrl_if #(.AWIDTH(4)) bus1 ();
    sort_ctrl_if #(.AWIDTH(4)) bus3 ();

    assign bus1.val_i       = val_r;
    assign bus1.sop_i       = sop_r;
    assign bus1.eop_i       = eop_r;
    assign bus1.sort_done_i = done_r;
    assign bus3.val_i       = val_r;
    assign bus3.sop_i       = sop_r;
    assign bus3.eop_i       = eop_r;
    assign bus3.sort_done_i = done_r;

    sort_ctrl #(.AWIDTH(4), .RD_LATENCY(1)) dut1 (.clk_i(clk), .srst_i(srst), .bus(bus1.master));
    sort_ctrl #(.AWIDTH(4), .RD_LATENCY(3)) dut3 (.clk_i(clk), .srst_i(srst), .bus(bus3.master));

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Sample both instances mid-cycle
    always @(negedge clk) begin
        if (bus1.wr_en_o) begin
            wr_a.push_back(int'(bus1.wr_addr_o));
            if (bus1.busy_o) busy_wr++;
        end
        if (bus1.sort_start_o) begin
            st_c.push_back(cyc);
            st_len.push_back(int'(bus1.sort_len_o));
        end
        if (bus1.rd_en_o) begin
            rd_c.push_back(cyc);
            rd_a.push_back(int'(bus1.rd_addr_o));
        end
        if (bus1.val_o) begin
            vo_c.push_back(cyc);
            vo_f.push_back(int'({bus1.sop_o, bus1.eop_o, bus1.clear_o}));
        end
        if (bus1.restart_o) rs_c.push_back(cyc);
        if (bus1.overflow_o && ovf_c < 0) ovf_c = cyc;
        if (bus3.wr_en_o && bus3.busy_o) busy_wr3++;
        if (bus3.rd_en_o) rd3_c.push_back(cyc);
        if (bus3.val_o) begin
            vo3_c.push_back(cyc);
            vo3_f.push_back(int'({bus3.sop_o, bus3.eop_o, bus3.clear_o}));
        end
    end

    task automatic check_val(input string tag, input int obs, input int exp);
        nchk++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clr_logs();
        wr_a.delete(); st_c.delete(); st_len.delete(); rd_c.delete(); rd_a.delete();
        vo_c.delete(); vo_f.delete(); rs_c.delete();
        rd3_c.delete(); vo3_c.delete(); vo3_f.delete();
        ovf_c = -1; busy_wr = 0; busy_wr3 = 0;
    endtask

    // Present one word for one cycle
    task automatic word(input logic sp, input logic ep);
        val_r = 1'b1; sop_r = sp; eop_r = ep;
        @(posedge clk); #1;
        val_r = 1'b0; sop_r = 1'b0; eop_r = 1'b0;
    endtask

    // Back-to-back packet of n words; returns the cycle the eop word is presented
    task automatic send(input int n, output int t_eop);
        t_eop = 0;
        for (int i = 0; i < n; i++) begin
            if (i == n - 1) t_eop = cyc;
            word(i == 0, i == n - 1);
        end
    endtask

    // One-cycle sort_done pulse n edges from now; returns its cycle
    task automatic fire_done(input int n, output int sc);
        repeat (n) @(posedge clk);
        #1;
        done_r = 1'b1;
        sc = cyc;
        @(posedge clk); #1;
        done_r = 1'b0;
    endtask

    // Output framing on both instances: n consecutive words, sop on first, eop+clear on last
    task automatic chk_out(input string tag, input int n, input int t1, input int t3);
        int mid;
        check_val({tag, "_n1"}, vo_c.size(), n);
        check_val({tag, "_n3"}, vo3_c.size(), n);
        if (vo_c.size() > 0) begin
            check_val({tag, "_first1"}, vo_c[0], t1);
            check_val({tag, "_last1"}, vo_c[vo_c.size()-1], t1 + n - 1);
            check_val({tag, "_fflag1"}, vo_f[0], (n == 1) ? 7 : 4);
            check_val({tag, "_lflag1"}, vo_f[vo_f.size()-1], (n == 1) ? 7 : 3);
            mid = 0;
            for (int i = 1; i < vo_f.size() - 1; i++) mid |= vo_f[i];
            check_val({tag, "_mid1"}, mid, 0);
        end
        if (vo3_c.size() > 0) begin
            check_val({tag, "_first3"}, vo3_c[0], t3);
            check_val({tag, "_last3"}, vo3_c[vo3_c.size()-1], t3 + n - 1);
            check_val({tag, "_lflag3"}, vo3_f[vo3_f.size()-1], (n == 1) ? 7 : 3);
        end
    endtask

    function automatic int outs1();
        return int'({bus1.busy_o, bus1.wr_en_o, bus1.sort_start_o, bus1.rd_en_o, bus1.val_o,
                     bus1.sop_o, bus1.eop_o, bus1.clear_o, bus1.overflow_o, bus1.restart_o});
    endfunction

    function automatic int outs3();
        return int'({bus3.busy_o, bus3.wr_en_o, bus3.sort_start_o, bus3.rd_en_o, bus3.val_o,
                     bus3.sop_o, bus3.eop_o, bus3.clear_o, bus3.overflow_o, bus3.restart_o});
    endfunction

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1 srst = 1'b0;
        @(negedge clk);
        check_val("rst_outs1", outs1(), 0);
        check_val("rst_outs3", outs3(), 0);
        check_val("rst_len", int'(bus1.sort_len_o), 0);

        // 5-word packet, sort done 3 cycles after start
        clr_logs();
        @(posedge clk); #1;
        send(5, te);
        @(negedge clk);
        check_val("s1_busy", int'(bus1.busy_o), 1);
        check_val("s1_start", int'(bus1.sort_start_o), 1);
        check_val("s1_len", int'(bus1.sort_len_o), 5);
        fire_done(3, s);
        check_val("s1_done_at", s, te + 4);
        repeat (14) @(posedge clk);
        @(negedge clk);
        check_val("s1_idle1", int'(bus1.busy_o), 0);
        check_val("s1_idle3", int'(bus3.busy_o), 0);
        check_val("s1_nwr", wr_a.size(), 5);
        for (int i = 0; i < wr_a.size(); i++) check_val("s1_wraddr", wr_a[i], i);
        check_val("s1_nstart", st_c.size(), 1);
        if (st_c.size() > 0) check_val("s1_startcyc", st_c[0], te + 1);
        check_val("s1_nrd", rd_a.size(), 5);
        if (rd_c.size() > 0) check_val("s1_rdcyc", rd_c[0], s + 1);
        for (int i = 0; i < rd_a.size(); i++) check_val("s1_rdaddr", rd_a[i], i);
        chk_out("s1", 5, s + 2, s + 4);

        // Single-word packet bypasses the sort engine
        clr_logs();
        @(posedge clk); #1;
        send(1, te);
        repeat (10) @(posedge clk);
        #1;
        check_val("s2_nstart", st_c.size(), 0);
        check_val("s2_nwr", wr_a.size(), 1);
        if (wr_a.size() > 0) check_val("s2_wraddr", wr_a[0], 0);
        if (rd_c.size() > 0) check_val("s2_rdcyc", rd_c[0], te + 1);
        chk_out("s2", 1, te + 2, te + 4);

        // 20-word packet overflows a 16-word buffer
        clr_logs();
        send(20, te);
        @(negedge clk);
        check_val("s3_len", int'(bus1.sort_len_o), 16);
        check_val("s3_ovfcyc", ovf_c, te - 2);
        fire_done(1, s);
        repeat (26) @(posedge clk);
        @(negedge clk);
        check_val("s3_nwr", wr_a.size(), 16);
        if (wr_a.size() > 0) check_val("s3_lastwr", wr_a[wr_a.size()-1], 15);
        check_val("s3_ovfheld", int'(bus1.overflow_o), 1);
        chk_out("s3", 16, s + 2, s + 4);

        // Unterminated packet restarted by a sop on its third word
        clr_logs();
        @(posedge clk); #1;
        word(1'b1, 1'b0);
        word(1'b0, 1'b0);
        tr = cyc;
        send(4, te);
        @(negedge clk);
        check_val("s4_ovfclr", int'(bus1.overflow_o), 0);
        check_val("s4_nrestart", rs_c.size(), 1);
        if (rs_c.size() > 0) check_val("s4_restartcyc", rs_c[0], tr + 1);
        check_val("s4_nwr", wr_a.size(), 6);
        if (wr_a.size() == 6) begin
            check_val("s4_wr2", wr_a[2], 0);
            check_val("s4_wr5", wr_a[5], 3);
        end
        if (st_len.size() > 0) check_val("s4_len", st_len[0], 4);
        fire_done(1, s);
        repeat (12) @(posedge clk);
        #1;
        chk_out("s4", 4, s + 2, s + 4);

        // val_i held high while busy: nothing written, latency-3 flags trail rd_en by 3
        clr_logs();
        send(3, te);
        val_r = 1'b1;
        fire_done(2, s);
        repeat (15) @(posedge clk);
        #1 val_r = 1'b0;
        @(posedge clk); #1;
        check_val("s5_nwr", wr_a.size(), 3);
        check_val("s5_busywr1", busy_wr, 0);
        check_val("s5_busywr3", busy_wr3, 0);
        if (rd3_c.size() > 0 && vo3_c.size() > 0) check_val("s5_lat3", vo3_c[0] - rd3_c[0], 3);
        chk_out("s5", 3, s + 2, s + 4);

        // Synchronous reset in the middle of READ
        clr_logs();
        send(8, te);
        fire_done(1, s);
        @(posedge clk); #1;
        srst = 1'b1;
        @(posedge clk); #1;
        srst = 1'b0;
        @(negedge clk);
        check_val("s6_outs1", outs1(), 0);
        check_val("s6_outs3", outs3(), 0);
        check_val("s6_len", int'(bus1.sort_len_o), 0);
        check_val("s6_rdaddr", int'(bus1.rd_addr_o), 0);
        clr_logs();
        repeat (8) @(posedge clk);
        #1;
        check_val("s6_flush1", vo_c.size(), 0);
        check_val("s6_flush3", vo3_c.size(), 0);
        send(2, te);
        fire_done(1, s);
        repeat (12) @(posedge clk);
        #1;
        check_val("s6_nwr", wr_a.size(), 2);
        chk_out("s6b", 2, s + 2, s + 4);

        $display("Result: errors=%0d of %0d checks", errs, nchk);
        $finish;
    end

endmodule

// File: doc/sort_ctrl.md
# sort_ctrl

Parametrised control FSM for the packet sorter: receives one packet of words, drives the packet buffer's write port, starts the sort engine, then reads the sorted buffer back out as a packet. It sits between the input stream, the dual-port packet RAM and the sort engine. It generalises the previous controller with internal length counting, overflow and restart handling, single-word bypass, and configurable RAM read latency.

## Interface
- AWIDTH, 4: buffer address width; DEPTH = 2**AWIDTH words.
- RD_LATENCY, 1: RAM read latency in cycles (>= 1); output flags are delayed to match.

- clk_i  in  1  clock.
- srst_i  in  1  synchronous reset, active-high.
- val_i  in  1  input word valid.
- sop_i  in  1  input start of packet (qualified by val_i).
- eop_i  in  1  input end of packet (qualified by val_i).
- busy_o  out  1  input not accepted while high.
- wr_en_o  out  1  RAM write enable.
- wr_addr_o  out  AWIDTH  RAM write address.
- sort_start_o  out  1  one-cycle sort start pulse.
- sort_len_o  out  AWIDTH+1  packet length (1..DEPTH), stable from sort_start_o until return to IDLE.
- sort_done_i  in  1  sort engine finished (pulse or level).
- rd_en_o  out  1  RAM read enable.
- rd_addr_o  out  AWIDTH  RAM read address.
- val_o, sop_o, eop_o  out  1 each  output flags, aligned with RAM read data.
- clear_o  out  1  asserted with eop_o; sort engine/buffer clear.
- overflow_o  out  1  current packet exceeded DEPTH; held until next accepted sop.
- restart_o  out  1  one-cycle pulse: unterminated packet discarded by new sop.

## Operation
- States: IDLE, RECV, SORT, READ, DRAIN. Reset: IDLE, all outputs 0, counters 0.
- Word accepted when val_i && !busy_o. busy_o = 1 in SORT, READ, DRAIN (decoded from state register).
- IDLE: accepted word without sop_i ignored (no write). With sop_i: write addr 0, cnt=1, overflow_o cleared; eop_i also set -> len=1, go READ directly (no sort_start_o); else RECV.
- RECV, accepted word:
  - sop_i: restart — write addr 0, cnt=1, overflow_o cleared, restart_o pulse; eop_i handled as in IDLE.
  - else cnt < DEPTH: write at cnt, cnt++; else word dropped (wr_en_o=0), overflow_o set.
  - eop_i (not sop_i): len = count including this word, saturated at DEPTH; go SORT.
- cnt is AWIDTH+1 bits; wr_addr_o = cnt[AWIDTH-1:0].
- SORT: sort_start_o = 1 in first SORT cycle only; stay until sort_done_i; then READ. sort_done_i ignored in other states.
- READ: rd_en_o=1, rd_addr_o 0..len-1, one per cycle; after len-1 go DRAIN.
- Flag pipeline (RD_LATENCY stages) carries val (rd_en_o), sop (addr==0), eop (addr==len-1); val_o/sop_o/eop_o/clear_o are its last stage. len=1 -> sop_o and eop_o together.
- DRAIN: RD_LATENCY cycles, then IDLE.

## Timing
- Write: wr_en_o/wr_addr_o combinational from accepted input (same cycle).
- eop accepted at cycle T: busy_o=1 and sort_start_o=1 at T+1.
- sort_done_i at cycle S: first rd_en_o at S+1; first val_o/sop_o at S+1+RD_LATENCY.
- val_o high exactly len consecutive cycles; eop_o/clear_o on last; busy_o low the cycle after eop_o; new sop can be accepted in that cycle.
- Single-word packet accepted at T: rd_en_o at T+1, val_o/sop_o/eop_o at T+1+RD_LATENCY.
- srst_i mid-operation: next cycle IDLE, all outputs 0, flag pipeline flushed, packet lost.

## Structure
- Package sort_pkg: state enum type (IDLE, RECV, SORT, READ, DRAIN), shared with the sort engine for debug.
- Sub-module sort_flag_pipe: RD_LATENCY-deep shift register of {val, sop, eop} with synchronous reset.

## Test plan
- AWIDTH=4, RD_LATENCY=1, 5-word packet, sort_done_i 3 cycles after start -> writes addr 0..4, sort_len_o=5, reads 0..4, val_o 5 cycles, sop_o first, eop_o+clear_o last.
- Single word (sop+eop+val) -> no sort_start_o, one output word with sop_o=eop_o=1, 2 cycles after input.
- 20-word packet, AWIDTH=4 -> 16 writes, overflow_o from word 17, sort_len_o=16, 16 output words.
- sop at word 3 of unterminated packet, then 4-word packet -> restart_o pulse, sort_len_o=4, writes restart at 0.
- RD_LATENCY=3, val_i held high during busy -> no writes while busy_o, flags appear 3 cycles after rd_en_o.
- srst_i during READ -> all outputs 0 next cycle, IDLE, next packet processes normally.
